// File: rtl/pipe_hazard_ctrl.sv
// Hazard, flush and forwarding controller for a 5-stage MIPS pipeline.
// Tracks per-register valid bits, arbitrates freeze/branch/stall/jump and keeps bring-up counters.
module pipe_hazard_ctrl #(
    parameter int REG_W     = 5,
    parameter int BR_STAGE  = 1,
    parameter int FWD_EN    = 1,
    parameter int RF_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwrite,
    input  logic             br_taken,
    input  logic             ext_busy,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [3:0]       stage_vld,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retired_cnt
);

    // Per-cycle pipeline action, highest priority first in the decode below.
    typedef enum logic [2:0] {
        M_NORMAL,
        M_JUMP,
        M_HAZARD,
        M_BRANCH,
        M_FREEZE
    } mode_t;

    mode_t      mode;
    logic [3:0] vld;
    logic       hz_raw, hz, br, jp;

    function automatic logic hit(input logic we, input logic v,
                                 input logic [REG_W-1:0] rd, input logic [REG_W-1:0] src);
        return we & v & (rd != '0) & (rd == src);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        logic rs_ex, rt_ex, rs_mem, rt_mem, rs_wb, rt_wb;
        rs_ex  = id_uses_rs & hit(ex_regwrite,  vld[1], ex_rd,  id_rs);
        rt_ex  = id_uses_rt & hit(ex_regwrite,  vld[1], ex_rd,  id_rt);
        rs_mem = id_uses_rs & hit(mem_regwrite, vld[2], mem_rd, id_rs);
        rt_mem = id_uses_rt & hit(mem_regwrite, vld[2], mem_rd, id_rt);
        rs_wb  = id_uses_rs & hit(wb_regwrite,  vld[3], wb_rd,  id_rs);
        rt_wb  = id_uses_rt & hit(wb_regwrite,  vld[3], wb_rd,  id_rt);
        hz_raw = 1'b0;
        if (FWD_EN != 0)
            hz_raw = ex_memread & (rs_ex | rt_ex);
        else
            hz_raw = rs_ex | rt_ex | rs_mem | rt_mem | ((RF_BYPASS == 0) & (rs_wb | rt_wb));
    end

    assign hz = vld[0] & hz_raw;
    assign br = br_taken & vld[BR_STAGE+1];
    assign jp = id_jump & vld[0];

    always_comb begin
        if (ext_busy)  mode = M_FREEZE;
        else if (br)   mode = M_BRANCH;
        else if (hz)   mode = M_HAZARD;
        else if (jp)   mode = M_JUMP;
        else           mode = M_NORMAL;
    end

    // Outputs are forced quiet while reset is held.
    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!rst) begin
            case (mode)
                M_FREEZE: ;
                M_BRANCH: begin
                    pc_we       = 1'b1;
                    ifid_we     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = (BR_STAGE == 1);
                end
                M_HAZARD: idex_flush = 1'b1;
                M_JUMP: begin
                    pc_we      = 1'b1;
                    ifid_we    = 1'b1;
                    ifid_flush = 1'b1;
                end
                default: begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                end
            endcase
        end
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if ((FWD_EN != 0) && !rst) begin
            if (hit(mem_regwrite, vld[2], mem_rd, ex_rs))     fwd_a = 2'b10;
            else if (hit(wb_regwrite, vld[3], wb_rd, ex_rs))  fwd_a = 2'b01;
            if (hit(mem_regwrite, vld[2], mem_rd, ex_rt))     fwd_b = 2'b10;
            else if (hit(wb_regwrite, vld[3], wb_rd, ex_rt))  fwd_b = 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld         <= 4'b0000;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (mode != M_FREEZE) begin
                vld[0] <= ifid_we ? !ifid_flush : vld[0];
                vld[1] <= idex_flush ? 1'b0 : vld[0];
                vld[2] <= exmem_flush ? 1'b0 : vld[1];
                vld[3] <= vld[2];
            end
            if (mode == M_FREEZE || mode == M_HAZARD)
                stall_cnt <= sat_inc(stall_cnt);
            if (mode == M_BRANCH || mode == M_JUMP)
                flush_cnt <= sat_inc(flush_cnt);
            if (vld[3] && !ext_busy)
                retired_cnt <= sat_inc(retired_cnt);
        end
    end

    assign stage_vld = vld;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default instance plus a CNT_W=3 copy for saturation.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rs, id_uses_rt, id_jump, ex_regwrite, ex_memread;
    logic       mem_regwrite, wb_regwrite, br_taken, ext_busy;

    logic        pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [3:0]  stage_vld;
    logic [15:0] stall_cnt, flush_cnt, retired_cnt;

    logic        s_pc_we, s_ifid_we, s_ifid_flush, s_idex_flush, s_exmem_flush;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [3:0]  s_stage_vld;
    logic [2:0]  s_stall_cnt, s_flush_cnt, s_retired_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_jump(id_jump), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .br_taken(br_taken), .ext_busy(ext_busy),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .stage_vld(stage_vld), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .retired_cnt(retired_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .id_jump(id_jump), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .br_taken(br_taken), .ext_busy(ext_busy),
        .pc_we(s_pc_we), .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush),
        .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush), .fwd_a(s_fwd_a),
        .fwd_b(s_fwd_b), .stage_vld(s_stage_vld), .stall_cnt(s_stall_cnt),
        .flush_cnt(s_flush_cnt), .retired_cnt(s_retired_cnt)
    );

    task automatic idle_inputs();
        id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_jump = 0; ex_regwrite = 0; ex_memread = 0;
        mem_regwrite = 0; wb_regwrite = 0; br_taken = 0; ext_busy = 0;
    endtask

    // Four idle edges always leave stage_vld at 1111.
    task automatic fill_pipe();
        @(negedge clk);
        idle_inputs();
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        id_jump = 1'b1; br_taken = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++; if ({pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush} !== 5'b0) $display("FAIL reset_ctrl: got %b want 00000", {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush}); else pass_cnt++;
        total_cnt++; if ({fwd_a, fwd_b, stage_vld} !== 8'h00) $display("FAIL reset_fwd_vld: got %h want 00", {fwd_a, fwd_b, stage_vld}); else pass_cnt++;
        total_cnt++; if ({stall_cnt, flush_cnt, retired_cnt} !== 48'h0) $display("FAIL reset_cnt: got %h want 0", {stall_cnt, flush_cnt, retired_cnt}); else pass_cnt++;
    endtask

    task automatic test_idle();
        logic [3:0] exp_vld [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        for (int e = 0; e < 7; e++) begin
            #1;
            total_cnt++; if (pc_we !== 1'b1) $display("FAIL idle_pc_we[%0d]: got %b want 1", e, pc_we); else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++; if (stage_vld !== exp_vld[e]) $display("FAIL idle_vld[%0d]: got %b want %b", e, stage_vld, exp_vld[e]); else pass_cnt++;
        end
        // MEM/WB is valid ahead of edges 5, 6 and 7.
        total_cnt++; if (retired_cnt !== 16'd3) $display("FAIL idle_retired: got %0d want 3", retired_cnt); else pass_cnt++;
    endtask

    task automatic test_load_use();
        fill_pipe();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1;
        #1;
        total_cnt++; if ({pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush} !== 5'b00010) $display("FAIL load_use_ctrl: got %b want 00010", {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush}); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (stall_cnt !== 16'd1) $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cnt); else pass_cnt++;
        total_cnt++; if (stage_vld !== 4'b1101) $display("FAIL load_use_vld: got %b want 1101", stage_vld); else pass_cnt++;
        @(negedge clk);
        idle_inputs();
        #1;
        total_cnt++; if (pc_we !== 1'b1) $display("FAIL load_use_release: got %b want 1", pc_we); else pass_cnt++;
    endtask

    task automatic test_forward_ex();
        fill_pipe();
        ex_memread = 0; ex_regwrite = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1;
        #1;
        total_cnt++; if ({pc_we, ifid_we, idex_flush} !== 3'b110) $display("FAIL fwd_no_stall: got %b want 110", {pc_we, ifid_we, idex_flush}); else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        mem_rd = 8; mem_regwrite = 1; ex_rs = 8;
        #1;
        total_cnt++; if (fwd_a !== 2'b10) $display("FAIL fwd_next_cycle: got %b want 10", fwd_a); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 16'd1) $display("FAIL fwd_stall_cnt: got %0d want 1", stall_cnt); else pass_cnt++;
    endtask

    task automatic test_double_forward();
        fill_pipe();
        mem_rd = 5; wb_rd = 5; ex_rs = 5; ex_rt = 5; mem_regwrite = 1; wb_regwrite = 1;
        #1;
        total_cnt++; if (fwd_a !== 2'b10) $display("FAIL dbl_fwd_both: got %b want 10", fwd_a); else pass_cnt++;
        mem_regwrite = 0;
        #1;
        total_cnt++; if ({fwd_a, fwd_b} !== 4'b0101) $display("FAIL dbl_fwd_wb: got %b want 0101", {fwd_a, fwd_b}); else pass_cnt++;
        mem_regwrite = 1; mem_rd = 0; wb_rd = 0; ex_rs = 0; ex_rt = 0;
        #1;
        total_cnt++; if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL dbl_fwd_r0: got %b want 0000", {fwd_a, fwd_b}); else pass_cnt++;
    endtask

    task automatic test_branch_load_use();
        fill_pipe();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1; br_taken = 1;
        #1;
        total_cnt++; if ({pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush} !== 5'b11111) $display("FAIL br_hz_ctrl: got %b want 11111", {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush}); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (stage_vld[2:0] !== 3'b000) $display("FAIL br_hz_vld: got %b want 000", stage_vld[2:0]); else pass_cnt++;
        total_cnt++; if ({flush_cnt, stall_cnt} !== {16'd1, 16'd1}) $display("FAIL br_hz_cnt: got flush %0d stall %0d want 1 1", flush_cnt, stall_cnt); else pass_cnt++;
    endtask

    task automatic test_busy_branch();
        fill_pipe();
        br_taken = 1; ext_busy = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++; if ({pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush} !== 5'b0) $display("FAIL busy_ctrl[%0d]: got %b want 00000", c, {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush}); else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++; if (stage_vld !== 4'b1111) $display("FAIL busy_vld[%0d]: got %b want 1111", c, stage_vld); else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++; if (stall_cnt !== 16'd4) $display("FAIL busy_stall_cnt: got %0d want 4", stall_cnt); else pass_cnt++;
        ext_busy = 0;
        #1;
        total_cnt++; if ({ifid_flush, idex_flush, exmem_flush} !== 3'b111) $display("FAIL busy_drop_flush: got %b want 111", {ifid_flush, idex_flush, exmem_flush}); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (flush_cnt !== 16'd2) $display("FAIL busy_flush_cnt: got %0d want 2", flush_cnt); else pass_cnt++;
    endtask

    task automatic test_jump();
        fill_pipe();
        id_jump = 1;
        #1;
        total_cnt++; if ({pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush} !== 5'b11100) $display("FAIL jump_ctrl: got %b want 11100", {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush}); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (stage_vld !== 4'b1110) $display("FAIL jump_vld: got %b want 1110", stage_vld); else pass_cnt++;
        total_cnt++; if (flush_cnt !== 16'd3) $display("FAIL jump_flush_cnt: got %0d want 3", flush_cnt); else pass_cnt++;
    endtask

    task automatic test_saturate_and_reset();
        fill_pipe();
        ext_busy = 1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (stall_cnt !== 16'd9) $display("FAIL sat_wide_stall: got %0d want 9", stall_cnt); else pass_cnt++;
        total_cnt++; if (s_stall_cnt !== 3'd7) $display("FAIL sat_stall: got %0d want 7", s_stall_cnt); else pass_cnt++;
        total_cnt++; if (s_retired_cnt !== 3'd7) $display("FAIL sat_retired: got %0d want 7", s_retired_cnt); else pass_cnt++;
        total_cnt++; if (s_flush_cnt !== 3'd3) $display("FAIL sat_flush: got %0d want 3", s_flush_cnt); else pass_cnt++;
        ext_busy = 0; id_jump = 1;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if ({pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b} !== 9'b0) $display("FAIL midrst_ctrl: got %b want 0", {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b}); else pass_cnt++;
        total_cnt++; if ({stage_vld, s_stall_cnt, s_retired_cnt} !== 10'b0) $display("FAIL midrst_state: got %b want 0", {stage_vld, s_stall_cnt, s_retired_cnt}); else pass_cnt++;
        total_cnt++; if ({stall_cnt, flush_cnt, retired_cnt} !== 48'h0) $display("FAIL midrst_cnt: got %h want 0", {stall_cnt, flush_cnt, retired_cnt}); else pass_cnt++;
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (stage_vld !== 4'b0001) $display("FAIL midrst_resume: got %b want 0001", stage_vld); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load_use();
        test_forward_ex();
        test_double_forward();
        test_branch_load_use();
        test_busy_branch();
        test_jump();
        test_saturate_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
